// File: rtl/fcvt_w_s_pkg.sv
// Shared binary32 definitions: field widths, rounding modes, FSM encoding and integer saturation limits.
// Consumed by fcvt_w_s and fp_round_int.
package fcvt_w_s_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int SIG_W     = MAN_W + 1;
  localparam int BIAS      = 127;
  localparam int SHIFT_CAP = 26;

  // Exponent at which the significand LSB has weight 2^0, and the first
  // exponents whose magnitude no longer fits the signed/unsigned result.
  localparam logic [EXP_W-1:0] EXP_INT_LSB = EXP_W'(BIAS + MAN_W);
  localparam logic [EXP_W-1:0] EXP_OVF_S   = EXP_W'(BIAS + 31);
  localparam logic [EXP_W-1:0] EXP_OVF_U   = EXP_W'(BIAS + 32);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
  localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fcvt_w_s_if.sv
// Request/response bundle of the float-to-int converter.
// FCVT_UNSIGNED_EN adds the is_unsigned request bit.
interface fcvt_w_s_if;
  logic        start;
  logic [31:0] rs1;
  logic [2:0]  rm;
`ifdef FCVT_UNSIGNED_EN
  logic        is_unsigned;
`endif
  logic [31:0] out;
  logic        valid;
  logic        busy;
  logic [1:0]  fflags;

  modport master (
    output start, rs1, rm,
`ifdef FCVT_UNSIGNED_EN
    output is_unsigned,
`endif
    input  out, valid, busy, fflags
  );

  modport slave (
    input  start, rs1, rm,
`ifdef FCVT_UNSIGNED_EN
    input  is_unsigned,
`endif
    output out, valid, busy, fflags
  );
endinterface

// File: rtl/fp_round_int.sv
// Rounds an integer magnitude with guard/sticky bits per RISC-V rounding mode.
// Result is one bit wider so a carry out of the top bit stays visible.
module fp_round_int
  import fcvt_w_s_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_mag,
  input  logic         i_sign,
  input  logic         i_guard,
  input  logic         i_sticky,
  input  logic [2:0]   i_rm,
  output logic [W:0]   o_rounded,
  output logic         o_inexact
);
  logic w_inc;

  assign o_inexact = i_guard | i_sticky;

  always_comb begin
    w_inc = 1'b0;
    case (i_rm)
      RM_RNE:  w_inc = i_guard & (i_sticky | i_mag[0]);
      RM_RMM:  w_inc = i_guard;
      RM_RDN:  w_inc = i_sign & o_inexact;
      RM_RUP:  w_inc = ~i_sign & o_inexact;
      default: w_inc = 1'b0;  // RTZ and reserved encodings truncate
    endcase
  end

  assign o_rounded = {1'b0, i_mag} + {{W{1'b0}}, w_inc};
endmodule

// File: rtl/fcvt_w_s.sv
// Multi-cycle binary32 -> int32 converter (FCVT.W.S), one shift bit per cycle.
// Define FCVT_UNSIGNED_EN to add FCVT.WU.S via the is_unsigned request bit.
module fcvt_w_s
  import fcvt_w_s_pkg::*;
(
  input logic      clk,
  input logic      resetn,
  fcvt_w_s_if.slave bus
);
  state_t           r_state, w_next;
  logic [31:0]      r_op;
  logic [2:0]       r_rm;
  logic             r_uns, w_uns_in;
  logic [31:0]      r_mag;
  logic             r_guard, r_sticky, r_left, r_nan, r_ovf, r_min;
  logic [4:0]       r_cnt;
  logic [32:0]      r_rnd, w_rounded;
  logic             r_inx, w_inexact;
  logic [31:0]      r_out, w_res;
  logic             r_valid, w_nv, w_nx, w_busy;
  logic [1:0]       r_fflags;
  logic             w_sign, w_zs, w_max, w_ovf;
  logic [EXP_W-1:0] w_exp, w_rdist;
  logic [MAN_W-1:0] w_man;
  logic [4:0]       w_cnt;

`ifdef FCVT_UNSIGNED_EN
  assign w_uns_in = bus.is_unsigned;
`else
  assign w_uns_in = 1'b0;
`endif

  assign w_sign  = r_op[31];
  assign w_exp   = r_op[30:23];
  assign w_man   = r_op[22:0];
  assign w_zs    = (w_exp == '0);
  assign w_max   = &w_exp;
  assign w_ovf   = w_max | (w_exp >= (r_uns ? EXP_OVF_U : EXP_OVF_S));
  assign w_rdist = EXP_INT_LSB - w_exp;

  always_comb begin
    w_cnt = '0;
    if (!(w_zs || w_ovf)) begin
      if (w_exp >= EXP_INT_LSB)              w_cnt = 5'(w_exp - EXP_INT_LSB);
      else if (w_rdist > EXP_W'(SHIFT_CAP))  w_cnt = 5'(SHIFT_CAP);
      else                                   w_cnt = w_rdist[4:0];
    end
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_UNPACK;
      ST_UNPACK: w_next = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == '0) w_next = ST_ROUND;
      ST_ROUND:  w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
  end

  fp_round_int #(.W(32)) u_round (
    .i_mag     (r_mag),
    .i_sign    (w_sign),
    .i_guard   (r_guard),
    .i_sticky  (r_sticky),
    .i_rm      (r_rm),
    .o_rounded (w_rounded),
    .o_inexact (w_inexact)
  );

  // Saturation and flag selection on the rounded magnitude.
  always_comb begin
    w_res = '0;
    w_nv  = 1'b0;
    w_nx  = 1'b0;
    if (r_nan) begin
      w_res = r_uns ? SAT_U_MAX : SAT_S_MAX;
      w_nv  = 1'b1;
    end else if (r_uns) begin
      if (r_ovf) begin
        w_res = w_sign ? '0 : SAT_U_MAX;
        w_nv  = 1'b1;
      end else if (w_sign) begin
        if (r_rnd != '0) w_nv = 1'b1;
        else             w_nx = r_inx;
      end else if (r_rnd[32]) begin
        w_res = SAT_U_MAX;
        w_nv  = 1'b1;
      end else begin
        w_res = r_rnd[31:0];
        w_nx  = r_inx;
      end
    end else begin
      if (r_ovf) begin
        w_res = w_sign ? SAT_S_MIN : SAT_S_MAX;
        w_nv  = ~(w_sign & r_min);
      end else if (!w_sign && r_rnd >= 33'h0_8000_0000) begin
        w_res = SAT_S_MAX;
        w_nv  = 1'b1;
      end else if (w_sign && r_rnd > 33'h0_8000_0000) begin
        w_res = SAT_S_MIN;
        w_nv  = 1'b1;
      end else begin
        w_res = w_sign ? -r_rnd[31:0] : r_rnd[31:0];
        w_nx  = r_inx;
      end
    end
  end

  // NOTE: only the visible outputs are reset; the datapath is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_fflags <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_op  <= bus.rs1;
          r_rm  <= bus.rm;
          r_uns <= w_uns_in;
        end
        ST_UNPACK: begin
          r_mag    <= (w_zs || w_ovf) ? '0 : {8'd0, 1'b1, w_man};
          r_guard  <= 1'b0;
          r_sticky <= w_zs & (|w_man);
          r_cnt    <= w_cnt;
          r_left   <= (w_exp >= EXP_INT_LSB);
          r_nan    <= w_max & (|w_man);
          r_ovf    <= w_ovf;
          r_min    <= (w_exp == EXP_OVF_S) & ~(|w_man);
        end
        ST_SHIFT: if (r_cnt != '0) begin
          r_cnt <= r_cnt - 5'd1;
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        ST_ROUND: begin
          r_rnd <= w_rounded;
          r_inx <= w_inexact;
        end
        ST_DONE: begin
          r_out    <= w_res;
          r_fflags <= {w_nv, w_nx};
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out    = r_out;
  assign bus.valid  = r_valid;
  assign bus.busy   = w_busy;
  assign bus.fflags = r_fflags;
endmodule

// File: tb/tb_fcvt_w_s.sv
// Bench for fcvt_w_s: arithmetic reference model + directed literals + random stimulus.
// Define FCVT_UNSIGNED_EN to also exercise the unsigned conversion.
module tb_fcvt_w_s;
  typedef struct {
    logic [31:0] o;
    logic [1:0]  f;
    int          n;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  logic [31:0] last_out;
  logic [1:0]  last_f;
  int   last_lat;
  exp_t exp_q[$];

  fcvt_w_s_if bus();
  fcvt_w_s dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Exact real-number reference: value = sig * 2^(e-150), rounded by comparing the remainder to one half.
  function automatic exp_t model(input logic [31:0] op, input logic [2:0] m, input logic u);
    exp_t   r;
    logic   s;
    int     e, k, cmp;
    longint sig, ip, rem, half, mag, v;
    bit     inx, inc, nan;
    s   = op[31];
    e   = int'(op[30:23]);
    sig = longint'(op[22:0]);
    if (e != 0) sig = sig + (longint'(1) << 23);
    nan = (e == 255) && (op[22:0] != 0);
    inx = 0; cmp = -1; ip = 0;
    if (e == 255 || e >= 182) ip = longint'(1) << 40;
    else begin
      k = 150 - ((e == 0) ? 1 : e);
      if (k <= 0) ip = sig << (-k);
      else if (k > 40) inx = (sig != 0);
      else begin
        ip   = sig >> k;
        rem  = sig - (ip << k);
        half = longint'(1) << (k - 1);
        inx  = (rem != 0);
        cmp  = (rem < half) ? -1 : ((rem == half) ? 0 : 1);
      end
    end
    case (m)
      3'd0:    inc = (cmp > 0) || (cmp == 0 && ip[0]);
      3'd4:    inc = (cmp >= 0);
      3'd2:    inc = s && inx;
      3'd3:    inc = !s && inx;
      default: inc = 0;
    endcase
    mag = ip + (inc ? 1 : 0);
    v   = s ? -mag : mag;
    r.o = '0; r.f = 2'b00;
    if (nan) begin
      r.o = u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF; r.f = 2'b10;
    end else if (u) begin
      if (v > longint'(32'hFFFF_FFFF)) begin r.o = 32'hFFFF_FFFF; r.f = 2'b10; end
      else if (v < 0)                  begin r.o = 32'h0;         r.f = 2'b10; end
      else                             begin r.o = v[31:0];       r.f = {1'b0, inx}; end
    end else begin
      if (v > 64'sd2147483647)         begin r.o = 32'h7FFF_FFFF; r.f = 2'b10; end
      else if (v < -64'sd2147483648)   begin r.o = 32'h8000_0000; r.f = 2'b10; end
      else                             begin r.o = v[31:0];       r.f = {1'b0, inx}; end
    end
    if (e == 0 || e == 255 || e >= (u ? 159 : 158)) r.n = 0;
    else if (e >= 150)                              r.n = e - 150;
    else                                            r.n = (150 - e > 26) ? 26 : 150 - e;
    r.t0 = 0;
    return r;
  endfunction

  // Single compare process: result on every valid, busy on every cycle outside reset.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      if (bus.valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("spurious_valid", 64'(bus.valid), 64'(0));
        else begin
          e = exp_q.pop_front();
          last_out = bus.out;
          last_f   = bus.fflags;
          last_lat = cyc - e.t0;
          check("out", 64'(bus.out), 64'(e.o));
          check("fflags", 64'(bus.fflags), 64'(e.f));
          check("latency", 64'(last_lat), 64'(e.n + 4));
        end
      end
      check("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
    end
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    check({name, "_done"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic issue(input logic [31:0] op, input logic [2:0] m, input logic u);
    exp_t e;
    wait_done("idle");
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.rs1   = op;
    bus.rm    = m;
`ifdef FCVT_UNSIGNED_EN
    bus.is_unsigned = u;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    e    = model(op, m, u);
    e.t0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic run_lit(input string name, input logic [31:0] op, input logic [2:0] m, input logic u,
                         input logic [31:0] eo, input logic [1:0] ef);
    issue(op, m, u);
    wait_done(name);
    check({name, "_out"}, 64'(last_out), 64'(eo));
    check({name, "_flags"}, 64'(last_f), 64'(ef));
  endtask

  initial begin
    int v0;
    logic [31:0] op;
    logic [7:0]  ex;
    logic [22:0] mn;
    logic        u;
    bus.start = 1'b0;
    bus.rs1   = '0;
    bus.rm    = '0;
`ifdef FCVT_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    check("rst_out", 64'(bus.out), 64'(0));
    check("rst_valid", 64'(bus.valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_flags", 64'(bus.fflags), 64'(0));

    run_lit("pi_rne", 32'h4049_0FDB, 3'b000, 1'b0, 32'h0000_0003, 2'b01);
    check("pi_latency", 64'(last_lat), 64'(26));
    run_lit("p1p5_rne", 32'h3FC0_0000, 3'b000, 1'b0, 32'h0000_0002, 2'b01);
    run_lit("p2p5_rne", 32'h4020_0000, 3'b000, 1'b0, 32'h0000_0002, 2'b01);
    run_lit("p2p5_rmm", 32'h4020_0000, 3'b100, 1'b0, 32'h0000_0003, 2'b01);
    run_lit("m1p5_rdn", 32'hBFC0_0000, 3'b010, 1'b0, 32'hFFFF_FFFE, 2'b01);
    run_lit("m1p5_rtz", 32'hBFC0_0000, 3'b001, 1'b0, 32'hFFFF_FFFF, 2'b01);

    // Reset mid-shift must abort silently and clear the visible outputs.
    issue(32'h3F80_0001, 3'b000, 1'b0);
    repeat (5) @(posedge clk);
    v0 = n_valid;
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_out", 64'(bus.out), 64'(0));
    check("abort_flags", 64'(bus.fflags), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    repeat (40) @(posedge clk);
    check("abort_no_valid", 64'(n_valid - v0), 64'(0));

    run_lit("p2e31", 32'h4F00_0000, 3'b000, 1'b0, 32'h7FFF_FFFF, 2'b10);
    run_lit("m2e31", 32'hCF00_0000, 3'b000, 1'b0, 32'h8000_0000, 2'b00);
    run_lit("qnan", 32'h7FC0_0000, 3'b000, 1'b0, 32'h7FFF_FFFF, 2'b10);
    run_lit("ninf", 32'hFF80_0000, 3'b000, 1'b0, 32'h8000_0000, 2'b10);
    run_lit("nzero", 32'h8000_0000, 3'b000, 1'b0, 32'h0000_0000, 2'b00);

    // Start while busy is ignored: exactly one valid for one accepted request.
    v0 = n_valid;
    issue(32'h0000_0001, 3'b011, 1'b0);
    bus.start = 1'b1;
    bus.rs1   = 32'h3F80_0000;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("sub_rup");
    repeat (10) @(posedge clk);
    check("sub_rup_out", 64'(last_out), 64'(1));
    check("sub_rup_flags", 64'(last_f), 64'(2'b01));
    check("busy_start_ignored", 64'(n_valid - v0), 64'(1));
    run_lit("sub_rne", 32'h0000_0001, 3'b000, 1'b0, 32'h0000_0000, 2'b01);

`ifdef FCVT_UNSIGNED_EN
    run_lit("u_2e32", 32'h4F80_0000, 3'b000, 1'b1, 32'hFFFF_FFFF, 2'b10);
    run_lit("u_m1", 32'hBF80_0000, 3'b000, 1'b1, 32'h0000_0000, 2'b10);
    run_lit("u_m0p3", 32'hBE99_999A, 3'b001, 1'b1, 32'h0000_0000, 2'b01);
`endif

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 15))
        0:       ex = 8'd0;
        1:       ex = 8'd255;
        2:       ex = 8'($urandom_range(1, 120));
        default: ex = 8'($urandom_range(120, 165));
      endcase
      mn = 23'($urandom);
      if ($urandom_range(0, 3) == 0) mn = mn & 23'h7F_0000;
      op = {1'($urandom), ex, mn};
`ifdef FCVT_UNSIGNED_EN
      u = 1'($urandom);
`else
      u = 1'b0;
`endif
      issue(op, 3'($urandom_range(0, 7)), u);
    end
    wait_done("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
